// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v sync, data enable, pixel coordinates, strobes and frame counter.
// Defining VGA_OUT_DELAY_EN adds a SYNC_DLY-stage output pipeline that advances only on enabled edges.
module vga_timing_gen #(
    parameter int   CNT_W      = 12,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   FRAME_W    = 8,
    parameter int   SYNC_DLY   = 2
) (
    input  logic               clk_pixel,
    input  logic               rst,
    input  logic               clk_en,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int OUT_W   = 5 + 2 * CNT_W + FRAME_W;

    // Window bounds use one extra bit so a region ending exactly at 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0]   H_ACT_E  = (CNT_W + 1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   H_SYNC_S = (CNT_W + 1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   H_SYNC_E = (CNT_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   V_ACT_E  = (CNT_W + 1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   V_SYNC_S = (CNT_W + 1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   V_SYNC_E = (CNT_W + 1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [OUT_W-1:0] RST_BUS  = {~H_SYNC_POL, ~V_SYNC_POL, {(OUT_W - 2){1'b0}}};

    logic [CNT_W-1:0]   hc_q, hc_d, vc_q, vc_d;
    logic [FRAME_W-1:0] frameCnt_q, frameCnt_d;
    logic               started_q;
    logic [CNT_W:0]     hcExt, vcExt;
    logic               deDec, hSyncDec, vSyncDec, lineDec, frameDec;
    logic [OUT_W-1:0]   outBus_q, outBus_d, outFinal;

    // Decode of the current position plus next counter values; the frame counter skips the very first frame.
    always_comb begin
        hcExt    = {1'b0, hc_q};
        vcExt    = {1'b0, vc_q};
        deDec    = (hcExt < H_ACT_E) && (vcExt < V_ACT_E);
        hSyncDec = (hcExt >= H_SYNC_S) && (hcExt < H_SYNC_E);
        vSyncDec = (vcExt >= V_SYNC_S) && (vcExt < V_SYNC_E);
        lineDec  = (hc_q == {CNT_W{1'b0}});
        frameDec = lineDec && (vc_q == {CNT_W{1'b0}});

        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = {CNT_W{1'b0}};
            vc_d = (vc_q == V_LAST) ? {CNT_W{1'b0}} : vc_q + 1'b1;
        end

        frameCnt_d = frameCnt_q;
        if (frameDec && started_q) begin
            frameCnt_d = frameCnt_q + 1'b1;
        end

        outBus_d = {(hSyncDec ? H_SYNC_POL : ~H_SYNC_POL),
                    (vSyncDec ? V_SYNC_POL : ~V_SYNC_POL),
                    deDec, lineDec, frameDec,
                    (deDec ? hc_q : {CNT_W{1'b0}}),
                    (deDec ? vc_q : {CNT_W{1'b0}}),
                    frameCnt_d};
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            hc_q       <= {CNT_W{1'b0}};
            vc_q       <= {CNT_W{1'b0}};
            frameCnt_q <= {FRAME_W{1'b0}};
            started_q  <= 1'b0;
            outBus_q   <= RST_BUS;
        end else if (clk_en) begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            frameCnt_q <= frameCnt_d;
            started_q  <= 1'b1;
            outBus_q   <= outBus_d;
        end
    end

`ifdef VGA_OUT_DELAY_EN
    logic [OUT_W-1:0] dly_q [SYNC_DLY];

    // Delay stages share the pixel enable so latency is counted in pixels, not clocks.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DLY; i++) begin
                dly_q[i] <= RST_BUS;
            end
        end else if (clk_en) begin
            dly_q[0] <= outBus_q;
            for (int i = 1; i < SYNC_DLY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign outFinal = dly_q[SYNC_DLY-1];
`else
    assign outFinal = outBus_q;
`endif

    assign {h_sync, v_sync, de, line_start, frame_start, pix_x, pix_y, frame_cnt} = outFinal;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen in a tiny 7x5 raster mode; also covers VGA_OUT_DELAY_EN builds.
module tb_vga_timing_gen;

    localparam int H_ACT = 4, H_FRONT = 1, H_SW = 1, H_BACK = 1;
    localparam int V_ACT = 2, V_FRONT = 1, V_SW = 1, V_BACK = 1;
    localparam int H_TOT = H_ACT + H_FRONT + H_SW + H_BACK;
    localparam int V_TOT = V_ACT + V_FRONT + V_SW + V_BACK;
`ifdef VGA_OUT_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] fc;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  en;
        outs_t exp;
    } vec_t;

    logic       clk_pixel = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       h_sync, v_sync, de, line_start, frame_start;
    logic [3:0] pix_x, pix_y;
    logic [1:0] frame_cnt;
    outs_t      dutOut;

    int errors = 0;
    int checks = 0;
    int n = 0;

    vga_timing_gen #(
        .CNT_W(4), .H_ACTIVE(H_ACT), .H_FP(H_FRONT), .H_SYNC(H_SW), .H_BP(H_BACK),
        .V_ACTIVE(V_ACT), .V_FP(V_FRONT), .V_SYNC(V_SW), .V_BP(V_BACK),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .FRAME_W(2), .SYNC_DLY(2)
    ) dut (
        .clk_pixel(clk_pixel), .rst(rst), .clk_en(clk_en),
        .h_sync(h_sync), .v_sync(v_sync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk_pixel = ~clk_pixel;

    assign dutOut = {h_sync, v_sync, de, line_start, frame_start, pix_x, pix_y, frame_cnt};

    function automatic outs_t mkOut(logic hs, logic vs, logic d, logic ls, logic fs,
                                    int x, int y, int fc);
        outs_t o;
        o.hs = hs; o.vs = vs; o.de = d; o.ls = ls; o.fs = fs;
        o.x = 4'(x); o.y = 4'(y); o.fc = 2'(fc);
        return o;
    endfunction

    function automatic vec_t mkVec(logic r, logic e, outs_t o);
        vec_t v;
        v.rst = r; v.en = e; v.exp = o;
        return v;
    endfunction

    // Reference: n enabled edges since reset map to raster position n-1-DLY by plain arithmetic.
    function automatic outs_t modelOut(int cnt);
        outs_t o;
        int p, hc, vc;
        o = mkOut(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        if (cnt > DLY) begin
            p  = cnt - 1 - DLY;
            hc = p % H_TOT;
            vc = (p / H_TOT) % V_TOT;
            o.de = (hc < H_ACT) && (vc < V_ACT);
            o.x  = o.de ? 4'(hc) : 4'd0;
            o.y  = o.de ? 4'(vc) : 4'd0;
            o.hs = (hc >= H_ACT + H_FRONT) && (hc < H_ACT + H_FRONT + H_SW);
            o.vs = !((vc >= V_ACT + V_FRONT) && (vc < V_ACT + V_FRONT + V_SW));
            o.ls = (hc == 0);
            o.fs = (hc == 0) && (vc == 0);
            o.fc = 2'((p / (H_TOT * V_TOT)) % 4);
        end
        return o;
    endfunction

    task automatic applyStimulus(input logic r, input logic e);
        rst    = r;
        clk_en = e;
        @(posedge clk_pixel);
        if (r) n = 0;
        else if (e) n++;
        @(negedge clk_pixel);
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        checks++;
        if (dutOut !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d fc=%0d, expected hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d fc=%0d",
                     name, dutOut.hs, dutOut.vs, dutOut.de, dutOut.ls, dutOut.fs, dutOut.x, dutOut.y, dutOut.fc,
                     exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.x, exp.y, exp.fc);
        end
    endtask

    task automatic checkVal(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        vec_t  tbl[$];
        outs_t rstOut;
        int    fsSeen, lsSeen, hsSeen, vsLow;

        rstOut = mkOut(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Start-of-raster vectors, shifted by the delay stages when they are built in.
        tbl.push_back(mkVec(1'b1, 1'b1, rstOut));
        for (int i = 0; i < DLY; i++) tbl.push_back(mkVec(1'b0, 1'b1, rstOut));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b0, mkOut(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b0, mkOut(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0)));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0)));
        tbl.push_back(mkVec(1'b0, 1'b1, mkOut(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0)));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].en);
            checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Four full frames: strobe counts, sync widths and frame counter wrap 3 -> 0.
        applyStimulus(1'b1, 1'b0);
        checkOutput("frameSeqReset", rstOut);
        for (int i = 0; i < DLY; i++) applyStimulus(1'b0, 1'b1);
        fsSeen = 0; lsSeen = 0; hsSeen = 0; vsLow = 0;
        for (int i = 0; i < 4 * H_TOT * V_TOT; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (frame_start) begin
                checkVal($sformatf("frameCnt@frame%0d", fsSeen), int'(frame_cnt), fsSeen % 4);
                fsSeen++;
            end
            if (line_start) lsSeen++;
            if (h_sync) hsSeen++;
            if (!v_sync) vsLow++;
        end
        checkVal("frameStartCount", fsSeen, 4);
        checkVal("lineStartCount", lsSeen, 4 * V_TOT);
        checkVal("hSyncHighCount", hsSeen, 4 * V_TOT * H_SW);
        checkVal("vSyncLowCount", vsLow, 4 * V_SW * H_TOT);

        // Mid-frame reset while clk_en is low, then restart from (0,0).
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < DLY + 11; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("preReset", mkOut(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 0));
        applyStimulus(1'b1, 1'b0);
        checkOutput("midReset", rstOut);
        applyStimulus(1'b0, 1'b0);
        checkOutput("resetHold", rstOut);
        for (int i = 0; i < DLY; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("resetPipe", rstOut);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("restart", mkOut(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0));

        // Random enables and occasional resets against the arithmetic model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0));
            checkOutput($sformatf("rand[%0d]", i), modelOut(n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; next generation of the fixed 640x480 VGA controller.
- Generates h/v sync, data enable, active-pixel coordinates, line/frame start strobes and a frame counter for any mode set by parameters.
- Sits between the pixel clock domain and the pixel/RGB generators (stopwatch digit renderer, overlays).
- Raster order is active → front porch → sync → back porch, so pix_x/pix_y start at 0 on the first visible pixel.

Parameters:
- CNT_W, 12, width of horizontal/vertical counters and coordinate outputs
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, active level of h_sync (0 = active-low)
- V_SYNC_POL, 0, active level of v_sync
- FRAME_W, 8, frame counter width
- SYNC_DLY, 2, output delay in enabled cycles; used only with VGA_OUT_DELAY_EN

Ports:
- clk_pixel  in  1  pixel clock; only clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  pixel advance enable; all state holds when low
- h_sync  out  1  horizontal sync, level set by H_SYNC_POL
- v_sync  out  1  vertical sync, level set by V_SYNC_POL
- de  out  1  data enable, high on visible pixels
- pix_x  out  CNT_W  visible column; 0 when de=0
- pix_y  out  CNT_W  visible row; 0 when de=0
- line_start  out  1  one-cycle strobe at h position 0 of every line
- frame_start  out  1  one-cycle strobe at position (0,0)
- frame_cnt  out  FRAME_W  count of completed frames, wraps

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800 default).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525 default).
  - Both totals must be ≤ 2^CNT_W.
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1):
  - On an enabled edge, outputs register the decode of the current (hc,vc), then the counters advance.
  - hc wraps at H_TOTAL-1 → 0.
  - vc increments when hc wraps and itself wraps V_TOTAL-1 → 0.
- Reset (rst=1 at an edge, regardless of clk_en):
  - hc=vc=0, frame_cnt=0, de=0, pix_x=pix_y=0, line_start=frame_start=0.
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL (inactive levels).
- First enabled edge after reset release: de=1, pix=(0,0), line_start=1, frame_start=1, frame_cnt=0.
- Output decode:
  - de = (hc<H_ACTIVE) && (vc<V_ACTIVE).
  - pix_x = hc and pix_y = vc when de=1; both 0 otherwise.
  - h_sync is active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - v_sync is active for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; it changes only at hc=0.
  - line_start = (hc==0); frame_start = (hc==0 && vc==0).
- frame_cnt:
  - Increments on the same edge that registers frame_start=1, except the first frame after reset.
  - Value during frame k is k mod 2^FRAME_W.
- clk_en=0:
  - Counters and all outputs hold their values.
  - Strobes hold too: a strobe lasts until the next enabled edge, so consumers qualify strobes with clk_en.
- Reset mid-frame takes priority over clk_en and any counter wrap; restart is exactly as after power-up.

Optional Feature:
- Macro: VGA_OUT_DELAY_EN.
- Defined:
  - h_sync, v_sync, de, line_start, frame_start, pix_x, pix_y and frame_cnt each pass through a SYNC_DLY-stage shift register.
  - The shift register advances only on enabled edges, matching downstream pixel-pipeline latency.
  - Reset loads every stage with the reset values above.
  - The first active output appears SYNC_DLY enabled edges later than without the macro.
- Undefined: no delay stages; SYNC_DLY is ignored.

Test Plan:
- Reset, then release with clk_en=1 for one edge → de=1, frame_start=1, line_start=1, pix=(0,0), h_sync=v_sync=1.
- Run one line (800 edges) → de high on edges 1..640; h_sync low on edges 657..752; line_start repeats at edge 801.
- Run 3 frames → frame_start period 420000 edges; v_sync low for 1600 edges starting at line 490, hc=0; frame_cnt reads 0,1,2.
- clk_en high on alternate cycles → every output period exactly doubles; outputs constant on clk_en=0 cycles.
- Assert rst at pix=(300,200) for 1 cycle → next edge all outputs inactive/0; first enabled edge after release gives (0,0) with frame_start=1.
- Small mode (H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, H_SYNC_POL=1, FRAME_W=2) → h period 7, v period 35, h_sync high only at hc=5, frame_cnt wraps 3→0.
  - Repeat with VGA_OUT_DELAY_EN and SYNC_DLY=2 → identical waveforms shifted by 2 enabled edges.
